// File: rtl/floppy_pkg.sv
// Shared definitions for the Amiga floppy drive-ID reader: FSM state
// encoding, well-known drive ID values and default tick counts.
package floppy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MON_SETUP  = 3'd1,
        ST_MON_SEL    = 3'd2,
        ST_MOFF_SETUP = 3'd3,
        ST_MOFF_SEL   = 3'd4,
        ST_BIT_HIGH   = 3'd5,
        ST_BIT_LOW    = 3'd6,
        ST_DONE       = 3'd7
    } floppy_state_e;

    localparam logic [31:0] FLOPPY_ID_HD   = 32'hAAAA_AAAA;
    localparam logic [31:0] FLOPPY_ID_DD   = 32'hFFFF_FFFF;
    localparam logic [31:0] FLOPPY_ID_NONE = 32'h0000_0000;

    localparam int FLOPPY_DEF_SETUP_TICKS    = 8;
    localparam int FLOPPY_DEF_SEL_LOW_TICKS  = 8;
    localparam int FLOPPY_DEF_SEL_HIGH_TICKS = 8;

    // Terminal value of the 8-bit tick counter for a phase of n ticks.
    // A phase length of 0 behaves like 1.
    function automatic logic [7:0] tick_last(input int n);
        logic [7:0] last;
        if (n <= 1) begin
            last = 8'd0;
        end else begin
            last = 8'(n - 1);
        end
        return last;
    endfunction

    // Active-low select pattern with only the addressed drive pulled low.
    function automatic logic [3:0] sel_mask(input logic [1:0] drv);
        logic [3:0] onehot;
        onehot = 4'b0001 << drv;
        return ~onehot;
    endfunction

endpackage

// File: rtl/floppy_rdy_sync.sv
// Two-flop synchronizer for the drive _rdy line. Resets to 1 (line idle).
module floppy_rdy_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous line through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/floppy_drive_id_reader.sv
// Amiga floppy drive-ID reader. Toggles the motor latch of the selected
// drive on then off, then clocks 32 _sel pulses and assembles the ID MSB
// first from the inverted _rdy line.
// Build option: define FLOPPY_ID_RDY_SYNC_EN to pass _rdy through a
// two-flop synchronizer before it is sampled.
module floppy_drive_id_reader
    import floppy_pkg::*;
#(
    parameter int SETUP_TICKS    = FLOPPY_DEF_SETUP_TICKS,
    parameter int SEL_LOW_TICKS  = FLOPPY_DEF_SEL_LOW_TICKS,
    parameter int SEL_HIGH_TICKS = FLOPPY_DEF_SEL_HIGH_TICKS
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        clk7_en,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  drive,
    input  logic        _rdy,
    output logic        _motor,
    output logic [3:0]  _sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] id
);

    localparam logic [7:0] SETUP_LAST    = tick_last(SETUP_TICKS);
    localparam logic [7:0] SEL_LOW_LAST  = tick_last(SEL_LOW_TICKS);
    localparam logic [7:0] SEL_HIGH_LAST = tick_last(SEL_HIGH_TICKS);

    floppy_state_e state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [4:0]    bitcnt_q, bitcnt_d;
    logic [1:0]    drv_q, drv_d;
    logic [31:0]   shift_q, shift_d;
    logic [3:0]    sel_q, sel_d;
    logic          motor_q, motor_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   id_q, id_d;

    logic [7:0]    phase_last;
    logic          phase_expired;
    logic          rdy_s;

`ifdef FLOPPY_ID_RDY_SYNC_EN
    floppy_rdy_sync u_rdy_sync (
        .clk     (clk),
        .rst_n   (_reset),
        .async_i (_rdy),
        .sync_o  (rdy_s)
    );
`else
    // Line is already synchronous to clk (emulated drive).
    assign rdy_s = _rdy;
`endif

    // Select the terminal tick count for the current timed phase.
    always_comb begin
        phase_last = 8'd0;
        case (state_q)
            ST_MON_SETUP, ST_MOFF_SETUP:         phase_last = SETUP_LAST;
            ST_MON_SEL, ST_MOFF_SEL, ST_BIT_LOW: phase_last = SEL_LOW_LAST;
            ST_BIT_HIGH:                         phase_last = SEL_HIGH_LAST;
            default:                             phase_last = 8'd0;
        endcase
        phase_expired = (cnt_q == phase_last);
    end

    // Next-state and registered-output logic; everything advances on clk7_en.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        drv_d    = drv_q;
        shift_d  = shift_q;
        sel_d    = sel_q;
        motor_d  = motor_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        id_d     = id_q;

        if (clk7_en) begin
            if (abort && (state_q != ST_IDLE)) begin
                // Abandon the read; the last completed ID is kept.
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                sel_d   = 4'hF;
                motor_d = 1'b1;
                busy_d  = 1'b0;
            end else begin
                // Timed phases count up and restart from zero on every exit.
                if ((state_q != ST_IDLE) && (state_q != ST_DONE)) begin
                    cnt_d = phase_expired ? 8'd0 : cnt_q + 8'd1;
                end

                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            drv_d   = drive;
                            busy_d  = 1'b1;
                            motor_d = 1'b0;
                            cnt_d   = 8'd0;
                            shift_d = 32'd0;
                            state_d = ST_MON_SETUP;
                        end
                    end
                    ST_MON_SETUP: begin
                        if (phase_expired) begin
                            sel_d   = sel_mask(drv_q);
                            state_d = ST_MON_SEL;
                        end
                    end
                    ST_MON_SEL: begin
                        if (phase_expired) begin
                            sel_d   = 4'hF;
                            motor_d = 1'b1;
                            state_d = ST_MOFF_SETUP;
                        end
                    end
                    ST_MOFF_SETUP: begin
                        if (phase_expired) begin
                            sel_d   = sel_mask(drv_q);
                            state_d = ST_MOFF_SEL;
                        end
                    end
                    ST_MOFF_SEL: begin
                        if (phase_expired) begin
                            sel_d    = 4'hF;
                            bitcnt_d = 5'd0;
                            state_d  = ST_BIT_HIGH;
                        end
                    end
                    ST_BIT_HIGH: begin
                        if (phase_expired) begin
                            sel_d   = sel_mask(drv_q);
                            state_d = ST_BIT_LOW;
                        end
                    end
                    ST_BIT_LOW: begin
                        if (phase_expired) begin
                            // _rdy low while selected means an ID bit of 1.
                            shift_d = {shift_q[30:0], ~rdy_s};
                            sel_d   = 4'hF;
                            if (bitcnt_q == 5'd31) begin
                                state_d = ST_DONE;
                            end else begin
                                bitcnt_d = bitcnt_q + 5'd1;
                                state_d  = ST_BIT_HIGH;
                            end
                        end
                    end
                    ST_DONE: begin
                        id_d    = shift_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State and output registers with asynchronous return to idle.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            bitcnt_q <= 5'd0;
            drv_q    <= 2'd0;
            shift_q  <= 32'd0;
            sel_q    <= 4'hF;
            motor_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            id_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            drv_q    <= drv_d;
            shift_q  <= shift_d;
            sel_q    <= sel_d;
            motor_q  <= motor_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            id_q     <= id_d;
        end
    end

    assign _motor = motor_q;
    assign _sel   = sel_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign id     = id_q;

endmodule

// File: doc/floppy_drive_id_reader.md
Name: floppy_drive_id_reader

Overview:
Host-side initiator for the Amiga floppy drive-ID serial protocol (HRM Appendix H). On request it:
- latches the motor on, then off, in the selected drive;
- clocks 32 `_sel` low pulses, sampling the drive's `_rdy` line on each pulse;
- assembles a 32-bit ID, MSB first.

It sits between the floppy controller / OSD logic and a physical or emulated drive bus. It is used to detect HD (0xAAAAAAAA), DD (0xFFFFFFFF) or absent (0x00000000) drives.

Parameters:
- SETUP_TICKS, 8, clk7_en ticks between `_motor` change and the `_sel` falling edge.
- SEL_LOW_TICKS, 8, clk7_en ticks `_sel` is held low; `_rdy` is sampled on the last tick.
- SEL_HIGH_TICKS, 8, clk7_en ticks `_sel` is held high between pulses.

Ports:
- clk  in  1  system clock
- _reset  in  1  asynchronous, active-low reset
- clk7_en  in  1  7 MHz clock enable; all state advances only when high
- start  in  1  begin ID read; sampled in IDLE only
- abort  in  1  cancel read in progress
- drive  in  2  drive number 0-3 to query
- _rdy  in  1  drive ready/ID line, active low
- _motor  out  1  motor line, active low
- _sel  out  4  per-drive select, active low
- busy  out  1  read in progress
- done  out  1  one-clk pulse: id valid
- id  out  32  last completed ID

Behaviour:
Interface: one clock, `clk`; reset `_reset` is asynchronous and active-low.

Reset values: `_motor`=1, `_sel`=4'hF, `busy`=0, `done`=0, `id`=0. State is IDLE, counters are 0.

States and transitions (each transition on a clk7_en tick):
- IDLE: on start=1, latch `drive`, set busy=1, `_motor`=0 → MON_SETUP.
- MON_SETUP: wait SETUP_TICKS, then `_sel[drv]`=0 → MON_SEL.
- MON_SEL: wait SEL_LOW_TICKS, then `_sel[drv]`=1, `_motor`=1 → MOFF_SETUP.
- MOFF_SETUP: wait SETUP_TICKS, then `_sel[drv]`=0 → MOFF_SEL.
- MOFF_SEL: wait SEL_LOW_TICKS, then `_sel[drv]`=1, bitcnt=0 → BIT_HIGH.
- BIT_HIGH: wait SEL_HIGH_TICKS, then `_sel[drv]`=0 → BIT_LOW.
- BIT_LOW: on the last of SEL_LOW_TICKS:
  - shift `~_rdy` into shift register bit 0 (left shift);
  - set `_sel[drv]`=1;
  - if bitcnt==31 → DONE, else bitcnt+1 → BIT_HIGH.
- DONE: id <= shift register; done=1 for exactly one clk cycle; busy=0 → IDLE.

Timing and width rules:
- The tick counter is 8 bits, reloaded on every state entry. A parameter value of 0 is treated as 1.
- bitcnt is 5 bits.
- Total: exactly 34 `_sel` falling edges per read. Only `_sel[drv]` ever toggles; the other three stay 1.
- `_motor` stays 1 (off) through the whole bit phase.

Boundary conditions:
- start while busy: ignored.
- `drive` changes mid-read: ignored (latched value is used).
- abort, when busy: on the next clk7_en tick go to IDLE with `_sel`=4'hF, `_motor`=1, busy=0, no done, id unchanged.
- abort and start asserted together in IDLE: abort wins; stay idle.
- `_reset` mid-read: immediately return all outputs to reset values.
- clk7_en low: outputs hold.

Optional Feature:
Macro `FLOPPY_ID_RDY_SYNC_EN`.
- Defined: `_rdy` passes through a 2-flop synchronizer on clk (reset value 1) before sampling. Sample latency grows by 2 clk; tick timing is unchanged.
- Undefined: `_rdy` is sampled directly. For use when the line is already synchronous (emulated drive).

Decomposition:
Shared package (floppy_pkg) holds:
- state encoding constants;
- ID constants: FLOPPY_ID_HD=32'hAAAAAAAA, FLOPPY_ID_DD=32'hFFFFFFFF, FLOPPY_ID_NONE=32'h0;
- the default tick values.

One natural sub-module: floppy_rdy_sync (the 2-flop synchronizer), instantiated only under the macro.

Test Plan:
- HD responder model on drive 0 (motor-toggle then alternating `_rdy`), start → done after 34 `_sel[0]` falling edges, id=0xAAAAAAAA, busy low after done.
- DD model (`_rdy`=0 whenever selected), drive=1 → id=0xFFFFFFFF; `_sel[0]`, `_sel[2]` and `_sel[3]` never leave 1.
- No drive (`_rdy` tied 1), drive=3 → id=0x00000000, done pulses exactly one clk.
- Abort after 10 bit samples → `_sel`=4'hF and `_motor`=1 within one clk7_en tick; no done; id keeps prior value. A fresh start then yields the full correct ID.
- `_reset` low mid-MON_SEL → outputs return asynchronously to reset values. Start pulsed while busy is ignored: exactly 34 edges, a single done.
- With `FLOPPY_ID_RDY_SYNC_EN` defined, SEL_LOW_TICKS=3 → HD model still yields 0xAAAAAAAA; without the macro, identical result.
